// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit BLANK/DRIVE slots, a double-buffered
// display register committed at frame boundaries, and optional leading-zero suppression.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_suppress,
  output logic                    pending,
  output logic [3:0]              din,
  output logic                    digit_en,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int unsigned MaxDiv = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [CntW-1:0]         cnt_q;
  logic [4*NUM_DIGITS-1:0] active_val_q, shadow_val_q;
  logic [NUM_DIGITS-1:0]   active_dp_q, shadow_dp_q;

  logic [NUM_DIGITS-1:0]   suppressed;
  logic                    zero_run;
  logic [3:0]              drive_din;
  logic                    drive_dp;
  logic                    drive_en;

  // A digit is suppressed when it and every more significant digit show a bare zero.
  always_comb begin
    suppressed = '0;
    zero_run   = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_run      = zero_run & (active_val_q[4*i +: 4] == 4'h0) & ~active_dp_q[i];
      suppressed[i] = lz_suppress & zero_run;
    end
  end

  always_comb begin
    drive_din = active_val_q[4*idx_q +: 4];
    drive_dp  = active_dp_q[idx_q];
    drive_en  = ~suppressed[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending      <= 1'b0;
      anode        <= '0;
      din          <= '0;
      digit_en     <= 1'b0;
      dp           <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        shadow_val_q <= value;
        shadow_dp_q  <= dp_mask;
        pending      <= 1'b1;
      end
      unique case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_q     <= StDrive;
            cnt_q       <= '0;
            anode       <= NUM_DIGITS'(1) << idx_q;
            din         <= drive_din;
            dp          <= drive_dp;
            digit_en    <= drive_en;
            frame_start <= (idx_q == '0);
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            state_q  <= StBlank;
            cnt_q    <= '0;
            anode    <= '0;
            din      <= '0;
            dp       <= 1'b0;
            digit_en <= 1'b0;
            if (idx_q == IdxLast) begin
              idx_q <= '0;
              // Frame boundary: a load in this same cycle stays queued behind the old shadow.
              if (pending) begin
                active_val_q <= shadow_val_q;
                active_dp_q  <= shadow_dp_q;
                if (!load) pending <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q    <= cnt_q + CntW'(1);
            din      <= drive_din;
            dp       <= drive_dp;
            digit_en <= drive_en;
          end
        end
        default: state_q <= StBlank;
      endcase
    end
  end

endmodule
